// File: rtl/lcd_mem_scheduler.sv
// LCD dot/line timing, mode decode and interrupts, plus the shared VRAM/OAM read-port arbiter.
// Optional define CPU_LOCKOUT_EN enables mode-based CPU lockout (locked reads return 8'hFF).
//
// mode | meaning
// 0    | HBlank, CPU may access OAM and VRAM
// 1    | VBlank, CPU may access OAM and VRAM
// 2    | OAM scan, OAM locked
// 3    | pixel transfer, OAM and VRAM locked
module lcd_mem_scheduler #(
    parameter int unsigned DOTS_PER_LINE   = 456,
    parameter int unsigned LINES_PER_FRAME = 154,
    parameter int unsigned VISIBLE_LINES   = 144,
    parameter int unsigned OAM_DOTS        = 80,
    parameter int unsigned XFER_DOTS       = 172
) (
    input  logic        clk_hdmi,
    input  logic        rst,
    input  logic        dot_en,
    input  logic        lcd_enable,
    input  logic [7:0]  lyc,
    input  logic [3:0]  stat_sel,
    input  logic        cpu_req,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_is_oam,
    output logic        cpu_rd_valid,
    output logic [7:0]  cpu_rd_data,
    input  logic        disp_req,
    input  logic [12:0] disp_addr,
    input  logic        disp_is_oam,
    output logic        disp_grant,
    output logic        disp_rd_valid,
    output logic [12:0] rd_address,
    output logic        oe_oam,
    output logic        oe_vram,
    input  logic [7:0]  read_data,
    output logic [1:0]  mode,
    output logic [7:0]  ly,
    output logic        lyc_match,
    output logic        vblank_irq,
    output logic        stat_irq
);

    localparam int unsigned DOT_W = $clog2(DOTS_PER_LINE);

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_XFER   = 2'd3;

    logic [DOT_W-1:0] dot_q, dot_d;
    logic [7:0]       ly_q, ly_d;
    logic [1:0]       mode_q, mode_d;
    logic             vblank_q, vblank_d;
    logic             stat_q, stat_d;
    logic             stat_src_q, stat_src_d;

    logic [12:0]      rd_address_q, rd_address_d;
    logic             oe_oam_q, oe_oam_d;
    logic             oe_vram_q, oe_vram_d;
    logic             s1_cpu_q, s1_cpu_d;
    logic             s1_lock_q, s1_lock_d;
    logic             s1_disp_q, s1_disp_d;
    logic             cpu_rd_valid_q, cpu_rd_valid_d;
    logic [7:0]       cpu_rd_data_q, cpu_rd_data_d;
    logic             disp_rd_valid_q, disp_rd_valid_d;

    logic             oam_locked, vram_locked, cpu_locked;
    logic             cpu_busy, cpu_accept, disp_take;

    always_comb begin
        dot_d    = dot_q;
        ly_d     = ly_q;
        vblank_d = 1'b0;
        if (!lcd_enable) begin
            dot_d = '0;
            ly_d  = '0;
        end else if (dot_en) begin
            if (dot_q == DOT_W'(DOTS_PER_LINE - 1)) begin
                dot_d = '0;
                if (ly_q == 8'(LINES_PER_FRAME - 1)) begin
                    ly_d = '0;
                end else begin
                    ly_d     = ly_q + 8'd1;
                    vblank_d = (ly_q == 8'(VISIBLE_LINES - 1));
                end
            end else begin
                dot_d = dot_q + DOT_W'(1);
            end
        end
    end

    // Mode is decoded from the next counter values so it moves on the same edge as dot/ly.
    always_comb begin
        mode_d = MODE_HBLANK;
        if (!lcd_enable)
            mode_d = MODE_HBLANK;
        else if (ly_d >= 8'(VISIBLE_LINES))
            mode_d = MODE_VBLANK;
        else if (dot_d < DOT_W'(OAM_DOTS))
            mode_d = MODE_OAM;
        else if (dot_d < DOT_W'(OAM_DOTS + XFER_DOTS))
            mode_d = MODE_XFER;
        else
            mode_d = MODE_HBLANK;
    end

    always_comb begin
        stat_src_d = lcd_enable &
                     (((mode_d == MODE_HBLANK) & stat_sel[0]) |
                      ((mode_d == MODE_VBLANK) & stat_sel[1]) |
                      ((mode_d == MODE_OAM)    & stat_sel[2]) |
                      ((ly_d == lyc)           & stat_sel[3]));
        stat_d = stat_src_d & ~stat_src_q;
    end

    // Lock decision uses the mode register as it stands before this edge.
`ifdef CPU_LOCKOUT_EN
    assign oam_locked  = lcd_enable & ((mode_q == MODE_OAM) | (mode_q == MODE_XFER));
    assign vram_locked = lcd_enable & (mode_q == MODE_XFER);
`else
    assign oam_locked  = 1'b0;
    assign vram_locked = 1'b0;
`endif

    assign cpu_locked = cpu_is_oam ? oam_locked : vram_locked;
    assign disp_take  = disp_req & rst;
    // The CPU holds cpu_req until its valid pulse, so ignore it while its read is in flight.
    assign cpu_busy   = s1_cpu_q | cpu_rd_valid_q;
    assign cpu_accept = cpu_req & ~disp_req & ~cpu_busy;

    always_comb begin
        rd_address_d = rd_address_q;
        oe_oam_d     = 1'b0;
        oe_vram_d    = 1'b0;
        s1_disp_d    = disp_take;
        s1_cpu_d     = cpu_accept;
        s1_lock_d    = cpu_accept & cpu_locked;
        if (disp_take) begin
            rd_address_d = disp_addr;
            oe_oam_d     = disp_is_oam;
            oe_vram_d    = ~disp_is_oam;
        end else if (cpu_accept && !cpu_locked) begin
            rd_address_d = cpu_addr;
            oe_oam_d     = cpu_is_oam;
            oe_vram_d    = ~cpu_is_oam;
        end
    end

    always_comb begin
        cpu_rd_valid_d  = s1_cpu_q;
        disp_rd_valid_d = s1_disp_q;
        cpu_rd_data_d   = cpu_rd_data_q;
        if (s1_cpu_q)
            cpu_rd_data_d = s1_lock_q ? 8'hFF : read_data;
    end

    always_ff @(posedge clk_hdmi) begin
        if (!rst) begin
            dot_q           <= '0;
            ly_q            <= '0;
            mode_q          <= MODE_HBLANK;
            vblank_q        <= 1'b0;
            stat_q          <= 1'b0;
            stat_src_q      <= 1'b0;
            rd_address_q    <= '0;
            oe_oam_q        <= 1'b0;
            oe_vram_q       <= 1'b0;
            s1_cpu_q        <= 1'b0;
            s1_lock_q       <= 1'b0;
            s1_disp_q       <= 1'b0;
            cpu_rd_valid_q  <= 1'b0;
            cpu_rd_data_q   <= 8'h00;
            disp_rd_valid_q <= 1'b0;
        end else begin
            dot_q           <= dot_d;
            ly_q            <= ly_d;
            mode_q          <= mode_d;
            vblank_q        <= vblank_d;
            stat_q          <= stat_d;
            stat_src_q      <= stat_src_d;
            rd_address_q    <= rd_address_d;
            oe_oam_q        <= oe_oam_d;
            oe_vram_q       <= oe_vram_d;
            s1_cpu_q        <= s1_cpu_d;
            s1_lock_q       <= s1_lock_d;
            s1_disp_q       <= s1_disp_d;
            cpu_rd_valid_q  <= cpu_rd_valid_d;
            cpu_rd_data_q   <= cpu_rd_data_d;
            disp_rd_valid_q <= disp_rd_valid_d;
        end
    end

    assign mode          = mode_q;
    assign ly            = ly_q;
    assign lyc_match     = (ly_q == lyc);
    assign vblank_irq    = vblank_q;
    assign stat_irq      = stat_q;
    assign disp_grant    = disp_take;
    assign rd_address    = rd_address_q;
    assign oe_oam        = oe_oam_q;
    assign oe_vram       = oe_vram_q;
    assign cpu_rd_valid  = cpu_rd_valid_q;
    assign cpu_rd_data   = cpu_rd_data_q;
    assign disp_rd_valid = disp_rd_valid_q;

endmodule

// File: doc/lcd_mem_scheduler.md
Name: lcd_mem_scheduler

Overview:
- LCD timing sequencer and read-port arbiter for the VRAM/OAM read bus shared by the CPU and the display fetcher.
- Generates the dot counter, the line counter (LY) and the LCD mode (0-3), plus the VBlank and STAT interrupt pulses.
- Each cycle, grants the single rd_address/oe_oam/oe_vram port to one requester and enforces Game Boy mode-based CPU lockout.
- Sits between the CPU bus, the display driver and the VRAM/OAM memories.

Parameters:
- DOTS_PER_LINE, 456, dots per scanline.
- LINES_PER_FRAME, 154, total lines per frame, including VBlank.
- VISIBLE_LINES, 144, first VBlank line index.
- OAM_DOTS, 80, length of mode 2 in dots.
- XFER_DOTS, 172, length of mode 3 in dots.

Ports:
- clk_hdmi  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- dot_en  in  1  one-cycle dot tick; the timing counters advance only when it is high.
- lcd_enable  in  1  LCDC bit 7.
- lyc  in  8  LY compare value.
- stat_sel  in  4  STAT interrupt selects {lyc, mode2, mode1, mode0}.
- cpu_req  in  1  CPU read request (level, one request per cycle).
- cpu_addr  in  13  CPU read address.
- cpu_is_oam  in  1  1 = OAM target, 0 = VRAM target.
- cpu_rd_valid  out  1  CPU read data valid pulse.
- cpu_rd_data  out  8  CPU read data.
- disp_req  in  1  display fetch request.
- disp_addr  in  13  display fetch address.
- disp_is_oam  in  1  display target select (1 = OAM, 0 = VRAM).
- disp_grant  out  1  display request accepted this cycle.
- disp_rd_valid  out  1  display read data valid pulse.
- rd_address  out  13  shared memory read address.
- oe_oam  out  1  OAM output enable.
- oe_vram  out  1  VRAM output enable.
- read_data  in  8  shared memory read data.
- mode  out  2  current LCD mode.
- ly  out  8  current line.
- lyc_match  out  1  high when ly == lyc.
- vblank_irq  out  1  VBlank interrupt pulse.
- stat_irq  out  1  STAT interrupt pulse.

Behaviour:
- Reset (rst == 0 at a clock edge) clears dot, ly and all registered outputs.
  - mode = 0, cpu_rd_valid = 0, cpu_rd_data = 8'h00, disp_grant = 0, disp_rd_valid = 0.
  - rd_address = 0, oe_oam = 0, oe_vram = 0, vblank_irq = 0, stat_irq = 0.
  - Lookup stages and in-flight reads are discarded; no valid pulse follows a read interrupted by reset.
- lcd_enable == 0 holds dot = 0, ly = 0, mode = 0; CPU lockout is disabled; no interrupts are generated.
  - Re-enabling starts at line 0, dot 0, mode 2.
- Timing, on dot_en:
  - dot increments; at DOTS_PER_LINE-1, dot wraps to 0 and ly increments.
  - At ly == LINES_PER_FRAME-1 end of line, ly wraps to 0.
- Mode decode (registered, updated on the same edge as the counters):
  - ly >= VISIBLE_LINES: mode 1.
  - else dot < OAM_DOTS: mode 2.
  - else dot < OAM_DOTS+XFER_DOTS: mode 3.
  - else: mode 0.
- lyc_match is combinational from the ly and lyc registers.
- vblank_irq: one-cycle pulse on the edge where ly becomes VISIBLE_LINES.
- stat_irq:
  - Internal line s = (mode==0 & sel[0]) | (mode==1 & sel[1]) | (mode==2 & sel[2]) | (lyc_match & sel[3]).
  - stat_irq is a one-cycle pulse on a rising edge of s only; s staying high across a mode change gives no second pulse.
- Lockout:
  - OAM is locked in modes 2 and 3; VRAM is locked in mode 3.
  - Locked CPU reads do not touch memory and return 8'hFF.
- Arbitration (per cycle, fixed priority):
  - The display wins whenever disp_req is high; disp_grant is asserted the same cycle.
  - The CPU is served only if disp_req is low and its target is unlocked.
  - A CPU request that collides with the display is stalled: it is held and retried each cycle while cpu_req stays high. The CPU must keep cpu_req and cpu_addr stable until cpu_rd_valid.
- Pipeline:
  - Cycle N: request accepted.
  - Cycle N+1: registered rd_address and oe_* driven; exactly one oe is high, else both are 0.
  - Cycle N+2: read_data is captured. cpu_rd_valid pulses with cpu_rd_data, or disp_rd_valid pulses (the display samples read_data itself).
  - A locked CPU read also completes with cpu_rd_valid at N+2 and data FF.
  - Back-to-back grants are allowed, giving one access per cycle.
- Simultaneous dot_en and a mode change: the lock decision for cycle N uses the mode register value before the edge.

Optional Feature:
- Macro: CPU_LOCKOUT_EN.
- Defined: mode-based OAM/VRAM lockout and FF substitution as above.
- Undefined: the CPU is never locked; it is served whenever disp_req is low, in any mode. Timing and interrupts are unchanged. This build is for debug and memory-dump use.

Test Plan:
- Reset with rst = 0 for 2 cycles, then dot_en every cycle with lcd_enable = 1 -> mode sequence 2 (80 dots), 3 (172 dots), 0 (204 dots); ly = 1 after 456 dots.
- Run 144 lines -> vblank_irq pulses once as ly goes 143 -> 144; mode = 1 for lines 144-153; ly wraps to 0 after 70224 dots.
- lyc = 5, stat_sel = 4'b1000 -> exactly one stat_irq pulse on entering ly = 5. With stat_sel = 4'b1001 and the match falling in mode 0 -> still one pulse.
- CPU OAM read of 13'h0010 during mode 2 -> cpu_rd_valid at N+2, data 8'hFF, oe_oam never high. Same read in mode 0 with read_data = 8'hA5 -> cpu_rd_data = 8'hA5.
- disp_req and cpu_req to VRAM together in mode 0 -> disp_grant at N, CPU stalled 1 cycle, cpu_rd_valid at N+3, rd_address shows the display address then the CPU address.
- Assert rst with a CPU read in flight (N+1) -> no cpu_rd_valid afterwards; all outputs are at reset values on the next edge.
